// File: rtl/uart_apb_pkg.sv
// Shared constants and types for the UART APB register block.
package uart_apb_pkg;

    localparam logic [2:0] ADDR_TXDATA  = 3'd0;
    localparam logic [2:0] ADDR_RXDATA  = 3'd1;
    localparam logic [2:0] ADDR_STATUS  = 3'd2;
    localparam logic [2:0] ADDR_CTRL    = 3'd3;
    localparam logic [2:0] ADDR_INTEN   = 3'd4;
    localparam logic [2:0] ADDR_INTSTAT = 3'd5;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_TX_CNT_LSB = 8;
    localparam int ST_RX_CNT_LSB = 16;

    localparam int IS_RX_NE    = 0;
    localparam int IS_TX_EMPTY = 1;
    localparam int IS_RX_OVF   = 2;
    localparam int IS_TX_OVF   = 3;

    typedef struct packed {
        logic [15:0] baud_div;
        logic [13:0] rsvd;
        logic        lb_en;
        logic        uart_en;
    } ctrl_t;

endpackage

// File: rtl/uart_apb_regs_if.sv
// APB bus bundle between a bus master and the UART register block.
interface uart_apb_regs_if;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;

    modport master (output paddr, psel, penable, pwrite, pwdata, input prdata);
    modport slave  (input paddr, psel, penable, pwrite, pwdata, output prdata);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push & ~do_pop)
                count <= count + CW'(1);
            else if (do_pop & ~do_push)
                count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/uart_apb_regs.sv
// Zero-wait-state APB register block of the UART: TX/RX FIFOs, status, control, interrupts.
// Optional internal TX->RX loopback (CTRL[1]) is built only when UART_APB_LOOPBACK_EN is defined.
module uart_apb_regs
    import uart_apb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_W     = 8
) (
    input  logic              pclk,
    input  logic              preset,
    uart_apb_regs_if.slave    apb,
    output logic              uart_int,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              uart_en,
    output logic [15:0]       baud_div
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [2:0]        reg_sel;
    logic              setup_ph, access_ph, rd_setup, wr_commit;
    logic              wr_tx, wr_ctrl, wr_inten, wr_intstat;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0]     tx_count, rx_count;
    logic [DATA_W-1:0] tx_head, rx_head, rx_din;
    logic              tx_pop, rx_push, rx_pop, rx_armed;
    logic              rx_ovf, tx_ovf, rx_ovf_set, tx_ovf_set;
    logic [3:0]        inten, intstat;
    ctrl_t             ctrl, ctrl_wr;
    logic [31:0]       rd_data, prdata_q;
    logic              unused_bits;

    assign reg_sel    = apb.paddr[4:2];
    assign setup_ph   = apb.psel & ~apb.penable;
    assign access_ph  = apb.psel & apb.penable;
    assign rd_setup   = setup_ph & ~apb.pwrite;
    assign wr_commit  = access_ph & apb.pwrite;
    assign wr_tx      = wr_commit & (reg_sel == ADDR_TXDATA);
    assign wr_ctrl    = wr_commit & (reg_sel == ADDR_CTRL);
    assign wr_inten   = wr_commit & (reg_sel == ADDR_INTEN);
    assign wr_intstat = wr_commit & (reg_sel == ADDR_INTSTAT);

    // Pop only if the read that is now in its access phase actually returned a byte.
    assign rx_pop = rx_armed & access_ph & ~apb.pwrite & (reg_sel == ADDR_RXDATA);

`ifdef UART_APB_LOOPBACK_EN
    logic lb_en;
    assign lb_en    = ctrl.lb_en;
    assign tx_valid = ~tx_empty & ~lb_en;
    assign tx_pop   = ~tx_empty & (lb_en | tx_ready);
    assign rx_push  = lb_en ? tx_pop  : rx_valid;
    assign rx_din   = lb_en ? tx_head : rx_data;
`else
    assign tx_valid = ~tx_empty;
    assign tx_pop   = ~tx_empty & tx_ready;
    assign rx_push  = rx_valid;
    assign rx_din   = rx_data;
`endif

    assign tx_data    = tx_head;
    assign tx_ovf_set = wr_tx & tx_full & ~tx_pop;
    assign rx_ovf_set = rx_push & rx_full & ~rx_pop;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_tx_fifo (
        .clk(pclk), .rst(preset),
        .push(wr_tx), .din(apb.pwdata[DATA_W-1:0]), .pop(tx_pop),
        .dout(tx_head), .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_rx_fifo (
        .clk(pclk), .rst(preset),
        .push(rx_push), .din(rx_din), .pop(rx_pop),
        .dout(rx_head), .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    always_comb begin
        intstat              = '0;
        intstat[IS_RX_NE]    = ~rx_empty;
        intstat[IS_TX_EMPTY] = tx_empty;
        intstat[IS_RX_OVF]   = rx_ovf;
        intstat[IS_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        ctrl_wr          = '0;
        ctrl_wr.uart_en  = apb.pwdata[0];
        ctrl_wr.baud_div = apb.pwdata[31:16];
`ifdef UART_APB_LOOPBACK_EN
        ctrl_wr.lb_en    = apb.pwdata[1];
`endif
    end

    always_comb begin
        rd_data = '0;
        case (reg_sel)
            ADDR_RXDATA:  rd_data = rx_empty ? '0 : 32'(rx_head);
            ADDR_STATUS: begin
                rd_data[ST_TX_FULL]             = tx_full;
                rd_data[ST_TX_EMPTY]            = tx_empty;
                rd_data[ST_RX_FULL]             = rx_full;
                rd_data[ST_RX_EMPTY]            = rx_empty;
                rd_data[ST_TX_CNT_LSB +: 8]     = 8'(tx_count);
                rd_data[ST_RX_CNT_LSB +: 8]     = 8'(rx_count);
            end
            ADDR_CTRL:    rd_data = ctrl;
            ADDR_INTEN:   rd_data[3:0] = inten;
            ADDR_INTSTAT: rd_data[3:0] = intstat;
            default:      rd_data = '0;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            prdata_q <= '0;
            rx_armed <= 1'b0;
            ctrl     <= '0;
            inten    <= '0;
            rx_ovf   <= 1'b0;
            tx_ovf   <= 1'b0;
            uart_int <= 1'b0;
        end else begin
            if (rd_setup) prdata_q <= rd_data;
            rx_armed <= rd_setup & (reg_sel == ADDR_RXDATA) & ~rx_empty;
            if (wr_ctrl)  ctrl  <= ctrl_wr;
            if (wr_inten) inten <= apb.pwdata[3:0];
            // a new overflow in the same cycle as its W1C keeps the bit set
            rx_ovf   <= rx_ovf_set | (rx_ovf & ~(wr_intstat & apb.pwdata[IS_RX_OVF]));
            tx_ovf   <= tx_ovf_set | (tx_ovf & ~(wr_intstat & apb.pwdata[IS_TX_OVF]));
            uart_int <= |(intstat & inten);
        end
    end

    assign apb.prdata = prdata_q;
    assign uart_en    = ctrl.uart_en;
    assign baud_div   = ctrl.baud_div;

    assign unused_bits = ^{apb.paddr[31:5], apb.paddr[1:0], apb.pwdata};
endmodule
